// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter. The current owner may keep the grant for up to
// its weight in consecutive granted beats, then priority rotates past it.
module wrr_arbiter #(
  parameter int CLIENTS  = 8,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(CLIENTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CLIENTS-1:0]           request,
  input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
  input  logic                         stall,
  output logic [CLIENTS-1:0]           grant,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         grant_last
);

  // Handshake: request[i] is a level held until the cycle grant[i]=1; that
  // cycle is the transfer beat. grant is combinational with no bubble cycles.

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                owned_q, owned_d;
  logic [WEIGHT_W-1:0] count_q, count_d;

  logic [WEIGHT_W-1:0] eff_w [CLIENTS];
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    rot_idx;
  logic                rot_found;
  logic                cont;
  logic                has_winner;
  logic [IDX_W-1:0]    winner;
  logic                grant_en;
  logic [WEIGHT_W-1:0] next_cnt;

  // A zero weight still allows a single beat so the client is never starved.
  always_comb begin
    for (int i = 0; i < CLIENTS; i++) begin
      if (weight[i*WEIGHT_W +: WEIGHT_W] == '0)
        eff_w[i] = WEIGHT_W'(1);
      else
        eff_w[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Scan starting just after the last owner; the owner itself is checked last.
  always_comb begin
    rot_found = 1'b0;
    rot_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= CLIENTS; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % CLIENTS);
      if (!rot_found && request[cand]) begin
        rot_found = 1'b1;
        rot_idx   = cand;
      end
    end
  end

  always_comb begin
    cont       = owned_q && request[ptr_q] && (count_q < eff_w[ptr_q]);
    has_winner = cont || rot_found;
    winner     = cont ? ptr_q : rot_idx;
    grant_en   = has_winner && !stall && !reset;
    next_cnt   = cont ? (count_q + WEIGHT_W'(1)) : WEIGHT_W'(1);
    grant      = grant_en ? (CLIENTS'(1) << winner) : '0;
    grant_idx  = grant_en ? winner : '0;
    grant_last = grant_en && (next_cnt == eff_w[winner]);
  end

  // Stall freezes everything so an interrupted burst resumes with its budget.
  always_comb begin
    ptr_d   = ptr_q;
    owned_d = owned_q;
    count_d = count_q;
    if (!stall) begin
      if (grant_en) begin
        ptr_d   = winner;
        count_d = next_cnt;
        owned_d = !grant_last;
      end else begin
        owned_d = 1'b0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= IDX_W'(CLIENTS - 1);
      owned_q <= 1'b0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owned_q <= owned_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios with hand-written expectations,
// then randomized traffic checked against a behavioural reference model.
module tb_wrr_arbiter;

  localparam int C  = 4;
  localparam int W  = 4;
  localparam int IW = $clog2(C);
  localparam int EW = C + IW + 1;

  logic          clk;
  logic          reset;
  logic [C-1:0]  request;
  logic [C*W-1:0] weight;
  logic          stall;
  logic [C-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_last;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;

  // reference model state: who owned last, whether a burst is live, beats used
  int m_last;
  bit m_active;
  int m_used;

  wrr_arbiter #(.CLIENTS(C), .WEIGHT_W(W)) dut (
    .clock(clk), .reset(reset), .request(request), .weight(weight),
    .stall(stall), .grant(grant), .grant_idx(grant_idx), .grant_last(grant_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset   = 1'b1;
    request = '0;
    weight  = '0;
    stall   = 1'b0;
  end

  // ---------------- reference model ----------------
  function automatic int ew(input logic [C*W-1:0] wt, input int i);
    int v;
    v = int'(wt[i*W +: W]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [IW-1:0] idx_of(input logic [C-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < C; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic model(input logic [C-1:0] req, input logic [C*W-1:0] wt,
                       input logic st, input logic rst, output logic [EW-1:0] e);
    int order[$];
    int win;
    int nxt;
    bit cont;
    logic [C-1:0] g;
    e = '0;
    if (rst) begin
      m_last = C - 1; m_active = 0; m_used = 0;
      return;
    end
    win  = -1;
    cont = m_active && req[m_last] && (m_used < ew(wt, m_last));
    if (cont) win = m_last;
    else begin
      for (int k = 1; k <= C; k++) order.push_back((m_last + k) % C);
      foreach (order[j]) if (win < 0 && req[order[j]]) win = order[j];
    end
    if (st) return;
    if (win < 0) begin
      m_active = 0; m_used = 0;
      return;
    end
    nxt = cont ? m_used + 1 : 1;
    g = '0;
    g[win] = 1'b1;
    e = {g, IW'(win), (nxt == ew(wt, win))};
    m_last = win;
    m_used = nxt;
    m_active = (nxt != ew(wt, win));
  endtask

  // ---------------- driver tasks ----------------
  task automatic rstep(input logic [C-1:0] req, input logic [C*W-1:0] wt,
                       input logic st, input logic rst, output logic [EW-1:0] e);
    @(posedge clk);
    #1;
    request = req; weight = wt; stall = st; reset = rst;
    model(req, wt, st, rst, e);
    exp_q.push_back(e);
  endtask

  // Directed beat: expectation written by hand; the model is still stepped.
  task automatic dstep(input logic [C-1:0] req, input logic [C*W-1:0] wt,
                       input logic st, input logic rst,
                       input logic [C-1:0] eg, input logic el);
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    request = req; weight = wt; stall = st; reset = rst;
    model(req, wt, st, rst, e);
    exp_q.push_back({eg, idx_of(eg), el});
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {grant, grant_idx, grant_last};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL grant t=%0t req=%b stall=%b rst=%b got gnt=%b idx=%0d last=%b exp gnt=%b idx=%0d last=%b",
                 $time, request, stall, reset, grant, grant_idx, grant_last,
                 e[EW-1 -: C], e[IW:1], e[0]);
      end
      checks++;
      if (!$onehot0(grant) || ((grant & ~request) != '0)) begin
        errors++;
        $display("FAIL onehot_subset t=%0t got gnt=%b req=%b exp onehot0 subset of req", $time, grant, request);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [C*W-1:0] w1, w2, w3, w4, w5, w6, wr;
    logic [C-1:0] rq;
    logic [EW-1:0] e;
    logic [C-1:0] prev_g;
    checks = 0;
    errors = 0;
    m_last = C - 1; m_active = 0; m_used = 0;

    // 1: all weights 1, everyone requesting
    w1 = {4'd1, 4'd1, 4'd1, 4'd1};
    dstep('0, w1, 0, 1, 4'b0000, 0);
    dstep('0, w1, 0, 1, 4'b0000, 0);
    dstep(4'b1111, w1, 0, 0, 4'b0001, 1);
    dstep(4'b1111, w1, 0, 0, 4'b0010, 1);
    dstep(4'b1111, w1, 0, 0, 4'b0100, 1);
    dstep(4'b1111, w1, 0, 0, 4'b1000, 1);
    dstep(4'b1111, w1, 0, 0, 4'b0001, 1);

    // 2: unequal weights (c0=1, c1=2, c2=1, c3=3)
    w2 = {4'd3, 4'd1, 4'd2, 4'd1};
    dstep('0, w2, 0, 1, 4'b0000, 0);
    dstep(4'b1111, w2, 0, 0, 4'b0001, 1);
    dstep(4'b1111, w2, 0, 0, 4'b0010, 0);
    dstep(4'b1111, w2, 0, 0, 4'b0010, 1);
    dstep(4'b1111, w2, 0, 0, 4'b0100, 1);
    dstep(4'b1111, w2, 0, 0, 4'b1000, 0);
    dstep(4'b1111, w2, 0, 0, 4'b1000, 0);
    dstep(4'b1111, w2, 0, 0, 4'b1000, 1);
    dstep(4'b1111, w2, 0, 0, 4'b0001, 1);

    // 3: stall mid-burst keeps the remaining budget
    w3 = {4'd1, 4'd1, 4'd1, 4'd4};
    dstep('0, w3, 0, 1, 4'b0000, 0);
    dstep(4'b0011, w3, 0, 0, 4'b0001, 0);
    dstep(4'b0011, w3, 1, 0, 4'b0000, 0);
    dstep(4'b0011, w3, 1, 0, 4'b0000, 0);
    dstep(4'b0011, w3, 0, 0, 4'b0001, 0);
    dstep(4'b0011, w3, 0, 0, 4'b0001, 0);
    dstep(4'b0011, w3, 0, 0, 4'b0001, 1);
    dstep(4'b0011, w3, 0, 0, 4'b0010, 1);

    // 4: owner drops mid-burst, rotation happens the same cycle
    w4 = {4'd1, 4'd1, 4'd1, 4'd4};
    dstep('0, w4, 0, 1, 4'b0000, 0);
    dstep(4'b0101, w4, 0, 0, 4'b0001, 0);
    dstep(4'b0101, w4, 0, 0, 4'b0001, 0);
    dstep(4'b0100, w4, 0, 0, 4'b0100, 1);

    // 5: zero weight behaves as one, sole requester re-wins each cycle
    w5 = {4'd1, 4'd1, 4'd0, 4'd1};
    dstep('0, w5, 0, 1, 4'b0000, 0);
    dstep(4'b0010, w5, 0, 0, 4'b0010, 1);
    dstep(4'b0010, w5, 0, 0, 4'b0010, 1);
    dstep(4'b0010, w5, 0, 0, 4'b0010, 1);
    dstep(4'b0000, w5, 0, 0, 4'b0000, 0);

    // 6: reset in the middle of client 2's burst
    w6 = {4'd1, 4'd4, 4'd1, 4'd1};
    dstep('0, w6, 0, 1, 4'b0000, 0);
    dstep(4'b1111, w6, 0, 0, 4'b0001, 1);
    dstep(4'b1111, w6, 0, 0, 4'b0010, 1);
    dstep(4'b1111, w6, 0, 0, 4'b0100, 0);
    dstep(4'b1111, w6, 0, 1, 4'b0000, 0);
    dstep(4'b1111, w6, 0, 0, 4'b0001, 1);

    // all-ones weight: 15-beat burst by the sole requester
    dstep('0, '1, 0, 1, 4'b0000, 0);
    for (int i = 1; i <= 15; i++) dstep(4'b1000, '1, 0, 0, 4'b1000, i == 15);

    // randomized traffic against the model
    wr = $urandom();
    rq = '0;
    prev_g = '0;
    rstep('0, wr, 0, 1, e);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) wr = $urandom();
      for (int i = 0; i < C; i++) begin
        if (rq[i] && prev_g[i] && $urandom_range(0, 1) == 0) rq[i] = 1'b0;
        else if (!rq[i] && $urandom_range(0, 2) == 0) rq[i] = 1'b1;
      end
      rstep(rq, wr, ($urandom_range(0, 6) == 0), ($urandom_range(0, 99) == 0), e);
      prev_g = e[EW-1 -: C];
    end

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
